// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan controller built around one shared hex decoder.
// Latency: an_o/seg_o are registered one cycle behind the scan state; an accepted value is shown from the next frame wrap onward.
// Backpressure: one-entry pending register; value_ready stays low while it is full and it only empties at a frame wrap.
//
// Ports:
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   enable_i                       scan enable, low blanks the display and restarts at digit 0
//   value_i, dp_i, value_valid,    offered display value (8 nibbles) and decimal points
//   value_ready                    pending register free
//   dec_digit_o, dec_segment_i     nibble out to the shared decoder, active-low pattern back
//   seg_o, an_o                    registered active-low segment and anode drive
//   frame_o                        one-cycle pulse on every frame wrap
// Build option: LEAD_ZERO_BLANK_EN -- blank leading zero digits (digit 0 is always shown).
module seg_scan_ctrl #(
    parameter int NUM_DIG   = 8,
    parameter int DWELL_CYC = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic [31:0] value_i,
    input  logic [7:0]  dp_i,
    input  logic        value_valid,
    output logic        value_ready,
    output logic [3:0]  dec_digit_o,
    input  logic [7:0]  dec_segment_i,
    output logic [7:0]  seg_o,
    output logic [7:0]  an_o,
    output logic        frame_o
);

    // BLANK_CYC is always shorter than DWELL_CYC, so one counter sized for the dwell covers both phases.
    localparam int CW = (DWELL_CYC > 2) ? $clog2(DWELL_CYC) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIG - 1);
    // Anode bits for digits that do not exist are forced high.
    localparam logic [7:0]    DIG_MASK   = 8'((1 << NUM_DIG) - 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DRIVE = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [2:0]     idx, idx_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           wrap;

    logic [31:0]    disp_val;
    logic [7:0]     disp_dp;
    logic [31:0]    pend_val;
    logic [7:0]     pend_dp;
    logic           pend_full;

    logic [4:0]     nib_lsb;
    logic           blank_digit;
    logic [6:0]     seg_lo;
    logic [7:0]     an_drive;

    // The decoder's DP bit is ignored; the decimal point comes from the display register.
    logic           unused_dec_dp;
    assign unused_dec_dp = dec_segment_i[7];

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        wrap      = 1'b0;
        if (!enable_i) begin
            state_nxt = OFF;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                OFF: begin
                    state_nxt = DRIVE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
                DRIVE: begin
                    if (cnt == DWELL_LAST) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt = DRIVE;
                        cnt_nxt   = '0;
                        if (idx == IDX_LAST) begin
                            idx_nxt = '0;
                            wrap    = 1'b1;
                        end else begin
                            idx_nxt = idx + 3'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = OFF;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign frame_o = wrap;

    // ------------------------------------------------------------------
    // Pending and display registers. The display only changes on the
    // wrap, so a frame never mixes digits from two values.
    // ------------------------------------------------------------------
    assign value_ready = ~pend_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_val  <= '0;
            disp_dp   <= '0;
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_full <= 1'b0;
        end else if (wrap && pend_full) begin
            disp_val  <= pend_val;
            disp_dp   <= pend_dp;
            pend_full <= 1'b0;
        end else if (value_valid && !pend_full) begin
            pend_val  <= value_i;
            pend_dp   <= dp_i;
            pend_full <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Decoder feed and optional leading-zero suppression
    // ------------------------------------------------------------------
    assign nib_lsb     = {idx, 2'b00};
    assign dec_digit_o = disp_val[nib_lsb +: 4];

`ifdef LEAD_ZERO_BLANK_EN
    // zero_from[k] is set when nibbles k..NUM_DIG-1 are all zero.
    logic [7:0] zero_from;
    logic       run_zero;

    always_comb begin
        zero_from = '0;
        run_zero  = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            if (k < NUM_DIG) begin
                run_zero     = run_zero & (disp_val[4*k +: 4] == 4'h0);
                zero_from[k] = run_zero;
            end
        end
    end

    assign blank_digit = (idx != 3'd0) && zero_from[idx];
`else
    assign blank_digit = 1'b0;
`endif

    assign seg_lo   = blank_digit ? 7'h7F : dec_segment_i[6:0];
    assign an_drive = ~(8'h01 << idx) | ~DIG_MASK;

    // ------------------------------------------------------------------
    // Registered pin drive
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_o  <= 8'hFF;
            seg_o <= 8'hFF;
        end else if (state == DRIVE) begin
            an_o  <= an_drive;
            seg_o <= {~disp_dp[idx], seg_lo};
        end else begin
            an_o  <= 8'hFF;
            seg_o <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with NUM_DIG=4, DWELL_CYC=4, BLANK_CYC=2.
// Stimulus pushes the expected {an_o, seg_o} of every digit it expects to be shown;
// a negedge monitor pops one entry per displayed digit and also checks dwell, blank and frame timing.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int FRAME = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic [31:0] value_i;
    logic [7:0]  dp_i;
    logic        value_valid;
    logic        value_ready;
    logic [3:0]  dec_digit_o;
    logic [7:0]  dec_segment_i;
    logic [7:0]  seg_o;
    logic [7:0]  an_o;
    logic        frame_o;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIG   (ND),
        .DWELL_CYC (DWELL),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable_i),
        .value_i       (value_i),
        .dp_i          (dp_i),
        .value_valid   (value_valid),
        .value_ready   (value_ready),
        .dec_digit_o   (dec_digit_o),
        .dec_segment_i (dec_segment_i),
        .seg_o         (seg_o),
        .an_o          (an_o),
        .frame_o       (frame_o)
    );

    // External hex decoder: active-high a..g pattern (a = bit6), inverted onto the bus, DP bit off.
    function automatic logic [6:0] hex_abcdefg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    assign dec_segment_i = {1'b1, ~hex_abcdefg(dec_digit_o)};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected segment bytes for digits 0..3 of one frame.
    task automatic push4(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
        exp_q.push_back({8'hFE, s0});
        exp_q.push_back({8'hFD, s1});
        exp_q.push_back({8'hFB, s2});
        exp_q.push_back({8'hF7, s3});
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_o && n < 60);
        chk(name, 32'(frame_o), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int  cyc = 0;
    int  run = 0;
    int  gap = 0;
    int  last_frm = 0;
    bit  have_dig = 1'b0;
    bit  have_frm = 1'b0;

    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst_n) begin
            run = 0;
            gap = 0;
            have_dig = 1'b0;
            have_frm = 1'b0;
        end else begin
            cyc++;
            if (!enable_i) begin
                have_dig = 1'b0;
                have_frm = 1'b0;
            end
            if (an_o != 8'hFF) begin
                if (run == 0) begin
                    if (have_dig) chk("blank_len", 32'(gap), 32'(BLANK));
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_digit: an_o=%0h seg_o=%0h, expected no digit (t=%0t)",
                                 an_o, seg_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("digit_an", 32'(an_o), 32'(e[15:8]));
                        chk("digit_seg", 32'(seg_o), 32'(e[7:0]));
                    end
                end
                run++;
                gap = 0;
            end else begin
                if (run > 0) begin
                    chk("dwell_len", 32'(run), 32'(DWELL));
                    have_dig = 1'b1;
                    run = 0;
                end
                gap++;
            end
            if (frame_o) begin
                if (have_frm) chk("frame_period", 32'(cyc - last_frm), 32'(FRAME));
                last_frm = cyc;
                have_frm = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n       = 1'b0;
        enable_i    = 1'b0;
        value_i     = '0;
        dp_i        = '0;
        value_valid = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_an", 32'(an_o), 32'hFF);
        chk("rst_seg", 32'(seg_o), 32'hFF);
        chk("rst_frame", 32'(frame_o), 32'd0);
        chk("rst_ready", 32'(value_ready), 32'd1);

        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_an", 32'(an_o), 32'hFF);
        chk("post_rst_ready", 32'(value_ready), 32'd1);

        // Load a value while the scan is off: it waits in pending.
        value_i = 32'h0000_4321;
        dp_i = 8'h01;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        chk("ready_after_load", 32'(value_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("off_an", 32'(an_o), 32'hFF);

        // Frame 1 shows the reset display contents (all zero).
`ifdef LEAD_ZERO_BLANK_EN
        push4(8'h81, 8'hFF, 8'hFF, 8'hFF);
`else
        push4(8'h81, 8'h81, 8'h81, 8'h81);
`endif
        enable_i = 1'b1;
        @(negedge clk);
        chk("enable_lat_an", 32'(an_o), 32'hFF);
        @(negedge clk);
        chk("first_digit_an", 32'(an_o), 32'hFE);

        // Offer a second value while pending is full and keep offering it.
        repeat (4) @(negedge clk);
        value_i = 32'h0000_1234;
        dp_i = 8'h02;
        value_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready_mid", 32'(value_ready), 32'd0);

        wait_frame("frame1_seen");
        chk("bp_ready_wrap", 32'(value_ready), 32'd0);
        push4(8'h4F, 8'h92, 8'h86, 8'hCC);
        @(negedge clk);
        chk("bp_ready_after_wrap", 32'(value_ready), 32'd1);
        @(negedge clk);
        value_valid = 1'b0;
        chk("bp_accepted", 32'(value_ready), 32'd0);

        wait_frame("frame2_seen");
        chk("f2_ready_wrap", 32'(value_ready), 32'd0);
        push4(8'hCC, 8'h06, 8'h92, 8'hCF);
        @(negedge clk);
        chk("f2_ready_after", 32'(value_ready), 32'd1);

        // Mid-frame load: frame 3 must keep showing 1234 throughout.
        repeat (8) @(negedge clk);
        value_i = 32'h0000_0050;
        dp_i = 8'h00;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        chk("mid_load_ready", 32'(value_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("mid_load_ready_hold", 32'(value_ready), 32'd0);

        wait_frame("frame3_seen");
        chk("f3_ready_wrap", 32'(value_ready), 32'd0);
`ifdef LEAD_ZERO_BLANK_EN
        push4(8'h81, 8'hA4, 8'hFF, 8'hFF);
`else
        push4(8'h81, 8'hA4, 8'h81, 8'h81);
`endif
        @(negedge clk);
        chk("f3_ready_after", 32'(value_ready), 32'd1);

        // Frame 5 shows only digit 0 before enable drops in its blank gap.
        wait_frame("frame4_seen");
        chk("f4_ready_wrap", 32'(value_ready), 32'd1);
        exp_q.push_back({8'hFE, 8'h81});
        repeat (5) @(negedge clk);
        enable_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("drop_an", 32'(an_o), 32'hFF);
        chk("drop_seg", 32'(seg_o), 32'hFF);
        repeat (4) @(negedge clk);
        chk("drop_an_hold", 32'(an_o), 32'hFF);
        chk("drop_frame", 32'(frame_o), 32'd0);

        // Re-enable restarts at digit 0.
`ifdef LEAD_ZERO_BLANK_EN
        push4(8'h81, 8'hA4, 8'hFF, 8'hFF);
`else
        push4(8'h81, 8'hA4, 8'h81, 8'h81);
`endif
        enable_i = 1'b1;
        @(negedge clk);
        chk("reen_lat_an", 32'(an_o), 32'hFF);
        @(negedge clk);
        chk("reen_an", 32'(an_o), 32'hFE);
        chk("reen_seg", 32'(seg_o), 32'h81);

        wait_frame("frame5_seen");
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.push_back({8'hFE, 8'h81});
        value_i = 32'hDEAD_BEEF;
        dp_i = 8'hFF;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        chk("wrap_accept_empty", 32'(value_ready), 32'd0);

        // Reset in the middle of driving digit 0.
        for (int i = 0; i < 10 && an_o != 8'hFE; i++) @(negedge clk);
        chk("pre_reset_an", 32'(an_o), 32'hFE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_an", 32'(an_o), 32'hFF);
        chk("mid_rst_seg", 32'(seg_o), 32'hFF);
        chk("mid_rst_ready", 32'(value_ready), 32'd1);
        chk("mid_rst_frame", 32'(frame_o), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("hold_rst_an", 32'(an_o), 32'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_an", 32'(an_o), 32'hFF);
        chk("rel_ready", 32'(value_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
